// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog controller: FSM states, register map, STATUS layout.
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package wdt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_HOLD = 3'd4
  } wdt_state_e;

  localparam logic [3:0] WDT_CTRL_OFF   = 4'h0;
  localparam logic [3:0] WDT_KICK_OFF   = 4'h4;
  localparam logic [3:0] WDT_TOCNT_OFF  = 4'h8;
  localparam logic [3:0] WDT_STATUS_OFF = 4'hC;

  localparam int unsigned STS_TO_BIT    = 0;
  localparam int unsigned STS_ERR_BIT   = 1;
  localparam int unsigned STS_STATE_LSB = 2;
  localparam int unsigned STS_STATE_MSB = 4;

  // Registers are word-aligned; only bits [3:2] select one.
  function automatic logic [1:0] reg_index(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/wdt_regfile.sv
// Register file for the watchdog controller: decode, shadow TOCNT, CTRL.EN, sticky STATUS, read mux.
module wdt_regfile
  import wdt_pkg::*;
#(
  parameter int DATA_W = `AXI_DATA_BITS,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  input  wdt_state_e        state,
  input  logic              set_to,
  input  logic              en_clr,
  output logic              arm_req,
  output logic              kick_req,
  output logic [DATA_W-1:0] shadow,
  output logic              irq
);

  localparam logic [1:0] IDX_CTRL   = reg_index(WDT_CTRL_OFF);
  localparam logic [1:0] IDX_KICK   = reg_index(WDT_KICK_OFF);
  localparam logic [1:0] IDX_TOCNT  = reg_index(WDT_TOCNT_OFF);
  localparam logic [1:0] IDX_STATUS = reg_index(WDT_STATUS_OFF);

  logic [1:0]        idx;
  logic              wr_ctrl, wr_kick, wr_tocnt, wr_status;
  logic              en, sts_to, sts_err;
  logic              set_err;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_addr_bits;

  assign idx              = reg_addr[3:2];
  assign unused_addr_bits = ^reg_addr[1:0];

  always_comb begin
    wr_ctrl   = reg_we && (idx == IDX_CTRL);
    wr_kick   = reg_we && (idx == IDX_KICK);
    wr_tocnt  = reg_we && (idx == IDX_TOCNT);
    wr_status = reg_we && (idx == IDX_STATUS);
    arm_req   = wr_ctrl && reg_wdata[0] && (state == ST_IDLE) && (shadow != '0);
    kick_req  = wr_kick && (state == ST_RUN);
    // Zero-count arm attempts and writes while running both flag ERR.
    set_err   = (wr_ctrl && reg_wdata[0] && (state == ST_IDLE) && (shadow == '0)) ||
                ((wr_ctrl || wr_tocnt) && (state == ST_RUN));
  end

  always_comb begin
    rd_mux = '0;
    unique case (idx)
      IDX_CTRL:   rd_mux[0] = en;
      IDX_KICK:   rd_mux    = '0;
      IDX_TOCNT:  rd_mux    = shadow;
      IDX_STATUS: begin
        rd_mux[STS_TO_BIT]                    = sts_to;
        rd_mux[STS_ERR_BIT]                   = sts_err;
        rd_mux[STS_STATE_MSB:STS_STATE_LSB]   = state;
      end
      default:    rd_mux    = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      en        <= 1'b0;
      sts_to    <= 1'b0;
      sts_err   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (wr_tocnt && (state == ST_IDLE))
        shadow <= reg_wdata;
      if (arm_req)
        en <= 1'b1;
      else if (en_clr)
        en <= 1'b0;
      // Set has priority over a same-cycle write-1-to-clear.
      sts_to  <= (sts_to  & ~(wr_status & reg_wdata[STS_TO_BIT]))  | set_to;
      sts_err <= (sts_err & ~(wr_status & reg_wdata[STS_ERR_BIT])) | set_err;
      if (reg_re)
        reg_rdata <= rd_mux;
    end
  end

  assign irq = sts_to;

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: sequences load/enable/kick strobes to the core and holds reset after timeout.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int DATA_W   = `AXI_DATA_BITS,
  parameter int ADDR_W   = 4,
  parameter int RST_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              wden,
  output logic              wdlive,
  output logic [DATA_W-1:0] wtocnt,
  input  logic              wto,
  output logic              wdt_rst_req,
  output logic              wdt_irq
);

  localparam int CNT_W = $clog2(RST_HOLD + 1);

  wdt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  hold_cnt;
  logic              hold_done;
  logic              kick_q;
  logic              arm_req, kick_req;
  logic              set_to, en_clr;
  logic [DATA_W-1:0] shadow;

  wdt_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .state    (state_q),
    .set_to   (set_to),
    .en_clr   (en_clr),
    .arm_req  (arm_req),
    .kick_req (kick_req),
    .shadow   (shadow),
    .irq      (wdt_irq)
  );

  assign hold_done = (hold_cnt == CNT_W'(RST_HOLD - 1));
  assign set_to    = (state_q == ST_RUN) && wto;
  assign en_clr    = (state_q == ST_HOLD) && hold_done;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arm_req)   state_d = ST_LOAD;
      ST_LOAD:                state_d = ST_ARM;
      ST_ARM:                 state_d = ST_RUN;
      ST_RUN:  if (wto)       state_d = ST_HOLD;
      ST_HOLD: if (hold_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wtocnt      = (state_q == ST_LOAD) ? shadow : '0;
    wden        = (state_q == ST_ARM);
    wdt_rst_req = (state_q == ST_HOLD);
    wdlive      = kick_q;
  end

  // A timeout in the same cycle as a kick suppresses the kick.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      kick_q   <= 1'b0;
    end else begin
      hold_cnt <= (state_q == ST_HOLD) ? hold_cnt + 1'b1 : '0;
      kick_q   <= kick_req && !wto;
    end
  end

endmodule

// File: tb/tb_wdt_ctrl.sv
// Self-checking bench for wdt_ctrl: timestamp-based reference model plus directed literal checks.
module tb_wdt_ctrl;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int RST_HOLD = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_we, reg_re, wto;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata, wtocnt;
  logic              wden, wdlive, wdt_rst_req, wdt_irq;

  int checks = 0;
  int errors = 0;

  wdt_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .wden       (wden),
    .wdlive     (wdlive),
    .wtocnt     (wtocnt),
    .wto        (wto),
    .wdt_rst_req(wdt_rst_req),
    .wdt_irq    (wdt_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases derived from the edge at which arming and timeout happened.
  // Phase codes as reported in STATUS[4:2]: 0 idle, 1 load, 2 arm, 3 run, 4 hold.
  int          cyc = 0;
  int          arm_e = -1, to_e = -1, kick_e = -1;
  logic [31:0] m_shadow = '0, m_rdata = '0;
  logic        m_to = 1'b0, m_err = 1'b0;
  bit          mvalid = 1'b0;

  function automatic int phase(input int e);
    if (to_e >= 0 && e >= to_e && e < to_e + RST_HOLD) return 4;
    if (arm_e >= 0 && arm_e > to_e && e >= arm_e) begin
      if (e == arm_e)     return 1;
      if (e == arm_e + 1) return 2;
      return 3;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int   p;
    logic s_to, s_err;
    logic [1:0] clr, idx;
    cyc++;
    if (rst) begin
      mvalid = 1'b1;
      arm_e = -1; to_e = -1; kick_e = -1;
      m_shadow = '0; m_rdata = '0; m_to = 1'b0; m_err = 1'b0;
    end else begin
      p = phase(cyc - 1);
      s_to = 1'b0; s_err = 1'b0; clr = 2'b00;
      idx = reg_addr[3:2];
      if (reg_re) begin
        case (idx)
          2'd0: m_rdata = {31'd0, p != 0};
          2'd1: m_rdata = '0;
          2'd2: m_rdata = m_shadow;
          default: m_rdata = {27'd0, 3'(p), m_err, m_to};
        endcase
      end
      if (reg_we) begin
        if (idx == 2'd3) clr = reg_wdata[1:0];
        if (p == 0) begin
          if (idx == 2'd2) m_shadow = reg_wdata;
          if (idx == 2'd0 && reg_wdata[0]) begin
            if (m_shadow != 0) arm_e = cyc;
            else s_err = 1'b1;
          end
        end
        if (p == 3) begin
          if (idx == 2'd0 || idx == 2'd2) s_err = 1'b1;
          if (idx == 2'd1 && !wto) kick_e = cyc;
        end
      end
      if (p == 3 && wto) begin
        to_e = cyc;
        s_to = 1'b1;
      end
      m_to  = (m_to  & ~clr[0]) | s_to;
      m_err = (m_err & ~clr[1]) | s_err;
    end
  end

  always @(negedge clk) begin
    int p;
    if (mvalid) begin
      p = phase(cyc);
      check("model_wtocnt",  wtocnt,      (p == 1) ? m_shadow : 32'd0);
      check("model_wden",    32'(wden),   32'(p == 2));
      check("model_wdlive",  32'(wdlive), 32'(kick_e >= 0 && kick_e == cyc));
      check("model_rst_req", 32'(wdt_rst_req), 32'(p == 4));
      check("model_irq",     32'(wdt_irq), 32'(m_to));
      check("model_rdata",   reg_rdata,   m_rdata);
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    reg_re = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_re = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [4:0] wide_addr;
    rst = 1'b1; reg_we = 1'b0; reg_re = 1'b0; wto = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_wden", 32'(wden), 0);
    check("rst_rst_req", 32'(wdt_rst_req), 0);
    check("rst_irq", 32'(wdt_irq), 0);
    check("rst_rdata", reg_rdata, 0);

    // wto outside RUN is ignored
    wto = 1'b1; step(2); wto = 1'b0;
    check("idle_wto_irq", 32'(wdt_irq), 0);

    // Zero-count arm
    wr(4'h0, 32'h1);
    check("zero_arm_wtocnt", wtocnt, 0);
    step(1);
    check("zero_arm_wden", 32'(wden), 0);
    rd(4'hC); check("zero_arm_status", reg_rdata, 32'h2);
    rd(4'h0); check("zero_arm_ctrl", reg_rdata, 32'h0);
    wr(4'hC, 32'h2);
    rd(4'hC); check("err_w1c", reg_rdata, 32'h0);

    // Arm sequence
    wr(4'h8, 32'h20);
    wr(4'h0, 32'h1);
    check("arm_wtocnt_t1", wtocnt, 32'h20);
    check("arm_wden_t1", 32'(wden), 0);
    step(1);
    check("arm_wtocnt_t2", wtocnt, 32'h0);
    check("arm_wden_t2", 32'(wden), 1);
    step(1);
    check("arm_wden_t3", 32'(wden), 0);
    rd(4'hC); check("run_status", reg_rdata, 32'hC);

    // Back-to-back kicks
    reg_we = 1'b1; reg_addr = 4'h4; reg_wdata = 32'hDEAD;
    step(1);
    check("kick1_wdlive", 32'(wdlive), 1);
    step(1);
    reg_we = 1'b0;
    check("kick2_wdlive", 32'(wdlive), 1);
    step(1);
    check("kick_end_wdlive", 32'(wdlive), 0);

    // Locked TOCNT write
    wr(4'h8, 32'h99);
    rd(4'h8); check("locked_shadow", reg_rdata, 32'h20);
    rd(4'hC); check("locked_status", reg_rdata, 32'hE);
    wr(4'hC, 32'h2);

    // Timeout together with a kick
    wto = 1'b1; reg_we = 1'b1; reg_addr = 4'h4; reg_wdata = 32'h1;
    step(1);
    wto = 1'b0; reg_we = 1'b0;
    check("to_wdlive", 32'(wdlive), 0);
    check("to_rst_req_1", 32'(wdt_rst_req), 1);
    check("to_irq", 32'(wdt_irq), 1);
    for (int i = 2; i <= RST_HOLD; i++) begin
      step(1);
      check("to_rst_req_held", 32'(wdt_rst_req), 1);
    end
    step(1);
    check("to_rst_req_done", 32'(wdt_rst_req), 0);
    rd(4'h0); check("to_ctrl", reg_rdata, 32'h0);
    rd(4'hC); check("to_status", reg_rdata, 32'h1);

    // Reset in HOLD cycle 5
    wr(4'h0, 32'h1);
    step(3);
    wto = 1'b1; step(1); wto = 1'b0;
    check("hold_c1", 32'(wdt_rst_req), 1);
    step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    check("rst_mid_rst_req", 32'(wdt_rst_req), 0);
    check("rst_mid_irq", 32'(wdt_irq), 0);
    check("rst_mid_wden", 32'(wden), 0);
    check("rst_mid_wdlive", 32'(wdlive), 0);
    rd(4'hC); check("rst_mid_status", reg_rdata, 32'h0);
    rd(4'h8); check("rst_mid_shadow", reg_rdata, 32'h0);

    // Read latency, hold, and address wrap
    wr(4'h8, 32'h1234);
    rd(4'h8); check("rd_tocnt", reg_rdata, 32'h1234);
    step(3);
    check("rd_hold", reg_rdata, 32'h1234);
    wide_addr = 5'h10;
    rd(wide_addr[3:0]); check("rd_wrap_ctrl_idle", reg_rdata, 32'h0);
    wr(4'h0, 32'h1);
    step(3);
    rd(4'h1); check("rd_ctrl_low_bits", reg_rdata, 32'h1);
    rd(4'h4); check("rd_kick", reg_rdata, 32'h0);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
